// File: rtl/ddr_frame_writer.sv
// Buffers a 256-bit video word stream in a show-ahead FIFO and writes it to DDR as
// fixed-length AXI bursts, cycling through a ring of frame regions on frame_sync.
module ddr_frame_writer #(
    parameter int                         CTRL_ADDR_WIDTH = 28,
    parameter int                         MEM_DQ_WIDTH    = 32,
    parameter int                         BURST_LEN       = 16,
    parameter int                         FIFO_DEPTH      = 32,
    parameter int                         REGION_NUM      = 3,
    parameter logic [CTRL_ADDR_WIDTH-1:0] REGION_SIZE     = 28'h0200000,
    parameter logic [CTRL_ADDR_WIDTH-1:0] BASE_ADDR       = 28'h0,
    parameter logic [3:0]                 AXI_ID          = 4'h0
) (
    input  logic                         axi_aclk,
    input  logic                         axi_aresetn,
    input  logic                         ddr_init_done,
    input  logic                         in_valid,
    input  logic [MEM_DQ_WIDTH*8-1:0]    in_data,
    output logic                         in_ready,
    input  logic                         frame_sync,
    output logic [CTRL_ADDR_WIDTH-1:0]   axi_awaddr,
    output logic [3:0]                   axi_awuser_id,
    output logic [3:0]                   axi_awlen,
    output logic                         axi_awvalid,
    input  logic                         axi_awready,
    output logic [MEM_DQ_WIDTH*8-1:0]    axi_wdata,
    output logic [MEM_DQ_WIDTH-1:0]      axi_wstrb,
    input  logic                         axi_wready,
    input  logic                         axi_wusero_last,
    output logic [1:0]                   cur_region,
    output logic                         frame_done,
    output logic                         err_flag
);
    localparam int DW = MEM_DQ_WIDTH * 8;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(BURST_LEN + 1);
    localparam logic [CTRL_ADDR_WIDTH-1:0] STEP        = CTRL_ADDR_WIDTH'(BURST_LEN * 8);
    localparam logic [BW-1:0]              LAST_BEAT   = BW'(BURST_LEN - 1);
    localparam logic [CW-1:0]              BL_CNT      = CW'(BURST_LEN);
    localparam logic [CW-1:0]              DEPTH_CNT   = CW'(FIFO_DEPTH);
    localparam logic [1:0]                 LAST_REGION = 2'(REGION_NUM - 1);

    typedef enum logic [1:0] {S_IDLE, S_AW, S_W} state_t;

    state_t                       r_state;
    state_t                       w_next;
    logic [DW-1:0]                r_mem [FIFO_DEPTH];
    logic [PW-1:0]                r_wptr;
    logic [PW-1:0]                r_rptr;
    logic [CW-1:0]                r_count;
    logic [BW-1:0]                r_beat;
    logic [CTRL_ADDR_WIDTH-1:0]   r_awaddr;
    logic [CTRL_ADDR_WIDTH-1:0]   r_region_base;
    logic [1:0]                   r_region;
    logic                         r_sync_pending;
    logic                         r_frame_done;
    logic                         r_err;

    logic                         w_push;
    logic                         w_pop;
    logic                         w_apply;
    logic                         w_aw_hs;
    logic                         w_last_beat;
    logic                         w_underflow;
    logic                         w_bad_last;
    logic                         w_wrap;
    logic [CTRL_ADDR_WIDTH-1:0]   w_next_addr;
    logic [CTRL_ADDR_WIDTH-1:0]   w_next_base;

    assign in_ready      = axi_aresetn && (r_count != DEPTH_CNT);
    assign w_push        = in_valid && in_ready;
    assign axi_awvalid   = (r_state == S_AW);
    assign axi_awaddr    = r_awaddr;
    assign axi_awuser_id = AXI_ID;
    assign axi_awlen     = 4'(BURST_LEN - 1);
    assign axi_wdata     = r_mem[r_rptr];
    assign axi_wstrb     = '1;
    assign cur_region    = r_region;
    assign frame_done    = r_frame_done;
    assign err_flag      = r_err;

    assign w_next_addr = r_awaddr + STEP;
    assign w_wrap      = ((w_next_addr - r_region_base) == REGION_SIZE);
    assign w_next_base = (r_region == LAST_REGION) ? BASE_ADDR : r_region_base + REGION_SIZE;
    assign w_bad_last  = (r_state == S_W) && axi_wusero_last && (r_beat != LAST_BEAT);

    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // A pending frame switch wins over starting a new burst in IDLE.
    always_comb begin
        w_next      = r_state;
        w_apply     = 1'b0;
        w_aw_hs     = 1'b0;
        w_pop       = 1'b0;
        w_underflow = 1'b0;
        w_last_beat = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_sync_pending) begin
                    w_apply = 1'b1;
                end else if (ddr_init_done && (r_count >= BL_CNT)) begin
                    w_next = S_AW;
                end
            end
            S_AW: begin
                if (axi_awready) begin
                    w_aw_hs = 1'b1;
                    w_next  = S_W;
                end
            end
            S_W: begin
                if (axi_wready) begin
                    if (r_count == '0) begin
                        w_underflow = 1'b1;
                    end else begin
                        w_pop = 1'b1;
                        if (r_beat == LAST_BEAT) begin
                            w_last_beat = 1'b1;
                            w_next      = S_IDLE;
                        end
                    end
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk) begin
        if (w_push) begin
            r_mem[r_wptr] <= in_data;
        end
    end

    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn) begin
            r_wptr         <= '0;
            r_rptr         <= '0;
            r_count        <= '0;
            r_beat         <= '0;
            r_awaddr       <= BASE_ADDR;
            r_region_base  <= BASE_ADDR;
            r_region       <= 2'd0;
            r_sync_pending <= 1'b0;
            r_frame_done   <= 1'b0;
            r_err          <= 1'b0;
        end else begin
            r_frame_done   <= w_apply;
            r_sync_pending <= frame_sync || (r_sync_pending && !w_apply);
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            // Frame switch drops leftovers but keeps a word pushed in the same cycle.
            if (w_apply) begin
                r_rptr        <= r_wptr;
                r_count       <= {{PW{1'b0}}, w_push};
                r_region      <= (r_region == LAST_REGION) ? 2'd0 : r_region + 2'd1;
                r_region_base <= w_next_base;
                r_awaddr      <= w_next_base;
                if (r_count != '0) begin
                    r_err <= 1'b1;
                end
            end else begin
                if (w_pop) begin
                    r_rptr <= r_rptr + 1'b1;
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + 1'b1;
                end else if (!w_push && w_pop) begin
                    r_count <= r_count - 1'b1;
                end
            end
            if (w_aw_hs) begin
                r_beat <= '0;
            end else if (w_pop) begin
                r_beat <= r_beat + 1'b1;
            end
            if (w_last_beat) begin
                r_awaddr <= w_wrap ? r_region_base : w_next_addr;
            end
            if (w_underflow || w_bad_last) begin
                r_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ddr_frame_writer.sv
// Randomized bench for ddr_frame_writer; a queue-based model tracks FIFO contents and the
// region/offset arithmetic. A second instance with a tiny region checks in-region wrap.
module tb_ddr_frame_writer;
    localparam int          DW    = 256;
    localparam int          BL    = 16;
    localparam logic [27:0] RSIZE = 28'h0200000;
    localparam logic [27:0] RSMAL = 28'h0000100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rstn, init_done, in_valid, frame_sync, awready, wready, wlast;
    logic [DW-1:0] in_data;
    logic          in_ready, aw_valid, frame_done, err;
    logic [27:0]   aw_addr;
    logic [3:0]    aw_id, aw_len;
    logic [DW-1:0] wdata;
    logic [31:0]   wstrb;
    logic [1:0]    region;
    logic          in_ready_s, aw_valid_s, frame_done_s, err_s;
    logic [27:0]   aw_addr_s;
    logic [3:0]    aw_id_s, aw_len_s;
    logic [DW-1:0] wdata_s;
    logic [31:0]   wstrb_s;
    logic [1:0]    region_s;

    ddr_frame_writer u_dut (
        .axi_aclk(clk), .axi_aresetn(rstn), .ddr_init_done(init_done),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .frame_sync(frame_sync),
        .axi_awaddr(aw_addr), .axi_awuser_id(aw_id), .axi_awlen(aw_len),
        .axi_awvalid(aw_valid), .axi_awready(awready), .axi_wdata(wdata), .axi_wstrb(wstrb),
        .axi_wready(wready), .axi_wusero_last(wlast), .cur_region(region),
        .frame_done(frame_done), .err_flag(err)
    );

    ddr_frame_writer #(.REGION_SIZE(RSMAL)) u_small (
        .axi_aclk(clk), .axi_aresetn(rstn), .ddr_init_done(init_done),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_s), .frame_sync(frame_sync),
        .axi_awaddr(aw_addr_s), .axi_awuser_id(aw_id_s), .axi_awlen(aw_len_s),
        .axi_awvalid(aw_valid_s), .axi_awready(awready), .axi_wdata(wdata_s), .axi_wstrb(wstrb_s),
        .axi_wready(wready), .axi_wusero_last(wlast), .cur_region(region_s),
        .frame_done(frame_done_s), .err_flag(err_s)
    );

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [DW-1:0] model_q[$];
    int unsigned   m_region, m_off, m_off_s;
    logic [DW-1:0] obs_data[BL];
    logic [27:0]   obs_addr, obs_addr_s;
    bit            obs_to;
    logic [DW-1:0] ew;

    function automatic logic [27:0] exp_addr();
        return 28'(m_region * 32'h0200000 + m_off);
    endfunction

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] d;
        for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0; init_done = 1'b0; in_valid = 1'b0; in_data = '0;
        frame_sync = 1'b0; awready = 1'b0; wready = 1'b0; wlast = 1'b0;
        tick(); tick();
        rstn = 1'b1;
        tick();
        model_q.delete();
        m_region = 0; m_off = 0; m_off_s = 0;
    endtask

    task automatic push_word(input logic [DW-1:0] d);
        in_valid = 1'b1; in_data = d;
        model_q.push_back(d);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic model_burst_done();
        m_off   = (m_off + 128) % 32'h0200000;
        m_off_s = (m_off_s + 128) % 32'h100;
    endtask

    task automatic model_sync();
        m_region = (m_region + 1) % 3;
        m_off = 0; m_off_s = 0;
        model_q.delete();
    endtask

    // Drives one AW handshake and BL write beats, recording what the DUT presented.
    task automatic run_burst(input logic [15:0] sync_mask, input logic [15:0] last_mask);
        int i;
        obs_to = 1'b0;
        i = 0;
        while (!aw_valid && i < 64) begin tick(); i++; end
        if (!aw_valid) begin obs_to = 1'b1; return; end
        obs_addr = aw_addr; obs_addr_s = aw_addr_s;
        awready = 1'b1; tick(); awready = 1'b0;
        for (int b = 0; b < BL; b++) begin
            wready = 1'b1; wlast = last_mask[b]; frame_sync = sync_mask[b];
            obs_data[b] = wdata;
            tick();
        end
        wready = 1'b0; wlast = 1'b0; frame_sync = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0; init_done = 1'b1; in_valid = 1'b1; in_data = '1;
        frame_sync = 1'b1; awready = 1'b0; wready = 1'b0; wlast = 1'b0;
        tick(); tick();
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        n_cmp++; if (aw_valid !== 1'b0) begin n_bad++; $display("FAIL rst_awvalid: got %b want 0", aw_valid); end
        n_cmp++; if (aw_addr !== 28'h0) begin n_bad++; $display("FAIL rst_awaddr: got %h want 0", aw_addr); end
        n_cmp++; if ({region, frame_done, err} !== 4'b0) begin n_bad++; $display("FAIL rst_status: got %b want 0000", {region, frame_done, err}); end
        do_reset();
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_release_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (region !== 2'd0) begin n_bad++; $display("FAIL rst_sync_cleared: region %0d want 0", region); end
    endtask

    task automatic test_single_burst();
        do_reset();
        init_done = 1'b1;
        for (int i = 0; i < BL; i++) push_word(DW'(i));
        n_cmp++; if (aw_valid !== 1'b0) begin n_bad++; $display("FAIL t1_latency_early: awvalid %b want 0", aw_valid); end
        tick();
        n_cmp++; if (aw_valid !== 1'b1) begin n_bad++; $display("FAIL t1_latency: awvalid %b want 1", aw_valid); end
        n_cmp++; if (aw_addr !== exp_addr()) begin n_bad++; $display("FAIL t1_awaddr: got %h want %h", aw_addr, exp_addr()); end
        n_cmp++; if ({aw_len, aw_id} !== 8'hF0) begin n_bad++; $display("FAIL t1_awlen_id: got %h want f0", {aw_len, aw_id}); end
        n_cmp++; if (wstrb !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL t1_wstrb: got %h want ffffffff", wstrb); end
        run_burst(16'h0, 16'h8000);
        n_cmp++; if (obs_to !== 1'b0) begin n_bad++; $display("FAIL t1_timeout: got %b want 0", obs_to); end
        for (int b = 0; b < BL; b++) begin
            ew = (model_q.size() > 0) ? model_q.pop_front() : '0;
            n_cmp++; if (obs_data[b] !== ew) begin n_bad++; $display("FAIL t1_data[%0d]: got %h want %h", b, obs_data[b], ew); end
        end
        model_burst_done();
        n_cmp++; if (aw_addr !== exp_addr()) begin n_bad++; $display("FAIL t1_next_addr: got %h want %h", aw_addr, exp_addr()); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL t1_err: got %b want 0", err); end
    endtask

    task automatic test_init_gate_back_to_back();
        do_reset();
        for (int i = 0; i < 2 * BL; i++) push_word(rand_word());
        repeat (5) tick();
        n_cmp++; if (aw_valid !== 1'b0) begin n_bad++; $display("FAIL t2_gated_awvalid: got %b want 0", aw_valid); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL t2_full_in_ready: got %b want 0", in_ready); end
        init_done = 1'b1;
        for (int n = 0; n < 2; n++) begin
            run_burst(16'h0, 16'h8000);
            n_cmp++; if (obs_to !== 1'b0) begin n_bad++; $display("FAIL t2_timeout[%0d]: got %b want 0", n, obs_to); end
            n_cmp++; if (obs_addr !== exp_addr()) begin n_bad++; $display("FAIL t2_addr[%0d]: got %h want %h", n, obs_addr, exp_addr()); end
            for (int b = 0; b < BL; b++) begin
                ew = (model_q.size() > 0) ? model_q.pop_front() : '0;
                n_cmp++; if (obs_data[b] !== ew) begin n_bad++; $display("FAIL t2_data[%0d][%0d]: got %h want %h", n, b, obs_data[b], ew); end
            end
            model_burst_done();
            if (n == 0) begin
                n_cmp++; if (aw_valid !== 1'b0) begin n_bad++; $display("FAIL t2_idle_gap: awvalid %b want 0", aw_valid); end
                tick();
                n_cmp++; if (aw_valid !== 1'b1) begin n_bad++; $display("FAIL t2_b2b_start: awvalid %b want 1", aw_valid); end
            end
        end
    endtask

    task automatic test_awready_stall();
        int i;
        do_reset();
        init_done = 1'b1;
        for (int k = 0; k < BL; k++) push_word(rand_word());
        i = 0;
        while (!aw_valid && i < 64) begin tick(); i++; end
        n_cmp++; if (aw_valid !== 1'b1) begin n_bad++; $display("FAIL t3_aw_timeout: awvalid %b want 1", aw_valid); end
        wready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            n_cmp++;
            if ({aw_valid, aw_addr} !== {1'b1, exp_addr()} || wdata !== model_q[0]) begin
                n_bad++;
                $display("FAIL t3_stall[%0d]: awvalid %b addr %h head %h want 1 %h %h", c, aw_valid, aw_addr, wdata, exp_addr(), model_q[0]);
            end
        end
        wready = 1'b0;
        run_burst(16'h0, 16'h8000);
        for (int b = 0; b < BL; b++) begin
            ew = (model_q.size() > 0) ? model_q.pop_front() : '0;
            n_cmp++; if (obs_data[b] !== ew) begin n_bad++; $display("FAIL t3_data[%0d]: got %h want %h", b, obs_data[b], ew); end
        end
        model_burst_done();
    endtask

    task automatic test_frame_sync_ring();
        do_reset();
        init_done = 1'b1;
        for (int k = 0; k < BL; k++) push_word(rand_word());
        run_burst(16'h0108, 16'h8000);
        model_burst_done();
        n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL t4_done_early: got %b want 0", frame_done); end
        tick();
        model_sync();
        n_cmp++;
        if ({frame_done, region, aw_addr} !== {1'b1, 2'(m_region), exp_addr()}) begin
            n_bad++; $display("FAIL t4_apply: done %b region %0d addr %h want 1 %0d %h", frame_done, region, aw_addr, m_region, exp_addr());
        end
        tick();
        n_cmp++; if ({frame_done, region} !== {1'b0, 2'(m_region)}) begin n_bad++; $display("FAIL t4_merged: done %b region %0d want 0 %0d", frame_done, region, m_region); end
        for (int k = 0; k < BL; k++) push_word(rand_word());
        run_burst(16'h0, 16'h8000);
        n_cmp++; if (obs_addr !== exp_addr()) begin n_bad++; $display("FAIL t4_region1_addr: got %h want %h", obs_addr, exp_addr()); end
        model_burst_done();
        model_q.delete();
        for (int s = 0; s < 2; s++) begin
            frame_sync = 1'b1; tick(); frame_sync = 1'b0; tick();
            model_sync();
            n_cmp++;
            if ({frame_done, region, aw_addr} !== {1'b1, 2'(m_region), exp_addr()}) begin
                n_bad++; $display("FAIL t4_ring[%0d]: done %b region %0d addr %h want 1 %0d %h", s, frame_done, region, aw_addr, m_region, exp_addr());
            end
        end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL t4_err: got %b want 0", err); end
    endtask

    task automatic test_discard();
        logic [DW-1:0] keep;
        do_reset();
        init_done = 1'b1;
        for (int k = 0; k < 5; k++) push_word(rand_word());
        frame_sync = 1'b1; tick(); frame_sync = 1'b0;
        keep = rand_word();
        in_valid = 1'b1; in_data = keep; tick(); in_valid = 1'b0;
        model_sync();
        model_q.push_back(keep);
        n_cmp++;
        if ({frame_done, err, region, aw_addr} !== {1'b1, 1'b1, 2'(m_region), exp_addr()}) begin
            n_bad++; $display("FAIL t5_discard: done %b err %b region %0d addr %h want 1 1 %0d %h", frame_done, err, region, aw_addr, m_region, exp_addr());
        end
        begin
            bit seen = 1'b0;
            for (int c = 0; c < 20; c++) begin if (aw_valid) seen = 1'b1; tick(); end
            n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL t5_no_aw: awvalid seen %b want 0", seen); end
        end
        for (int k = 0; k < BL - 1; k++) push_word(rand_word());
        run_burst(16'h0, 16'h8000);
        n_cmp++; if (obs_addr !== exp_addr()) begin n_bad++; $display("FAIL t5_addr: got %h want %h", obs_addr, exp_addr()); end
        for (int b = 0; b < BL; b++) begin
            ew = (model_q.size() > 0) ? model_q.pop_front() : '0;
            n_cmp++; if (obs_data[b] !== ew) begin n_bad++; $display("FAIL t5_data[%0d]: got %h want %h", b, obs_data[b], ew); end
        end
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL t5_err_sticky: got %b want 1", err); end
    endtask

    task automatic test_region_wrap();
        do_reset();
        init_done = 1'b1;
        for (int n = 0; n < 3; n++) begin
            for (int k = 0; k < BL; k++) push_word(rand_word());
            run_burst(16'h0, 16'h8000);
            model_q.delete();
            n_cmp++;
            if (obs_addr_s !== 28'(m_off_s) || obs_addr !== exp_addr()) begin
                n_bad++; $display("FAIL t6_wrap[%0d]: small %h big %h want %h %h", n, obs_addr_s, obs_addr, 28'(m_off_s), exp_addr());
            end
            model_burst_done();
        end
    endtask

    task automatic test_bad_last();
        do_reset();
        init_done = 1'b1;
        for (int k = 0; k < BL; k++) push_word(rand_word());
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL t7_err_before: got %b want 0", err); end
        run_burst(16'h0, 16'h0020);
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL t7_early_last: err %b want 1", err); end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_burst();
        test_init_gate_back_to_back();
        test_awready_stall();
        test_frame_sync_ring();
        test_discard();
        test_region_wrap();
        test_bad_last();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ddr_frame_writer.md
Name: ddr_frame_writer

Overview:
- Upstream write master for the DDR3_50H controller AXI write channel, on the controller's axi_aclk.
- Accepts a 256-bit video word stream and buffers it in an internal show-ahead FIFO.
- Issues fixed-length write bursts into a ring of REGION_NUM frame regions, providing frame buffering for the downstream read path.

Parameters:
- CTRL_ADDR_WIDTH, 28, controller address width (row+column+bank).
- MEM_DQ_WIDTH, 32, DDR data width; AXI data is MEM_DQ_WIDTH*8 bits.
- BURST_LEN, 16, beats per burst (1..16); axi_awlen = BURST_LEN-1.
- FIFO_DEPTH, 32, internal FIFO words; power of 2, at least 2*BURST_LEN.
- REGION_NUM, 3, number of frame regions in the ring.
- REGION_SIZE, 28'h0200000, address span per region; multiple of BURST_LEN*8.
- BASE_ADDR, 28'h0, address of region 0.
- AXI_ID, 4'h0, value driven on axi_awuser_id.

Ports:
- axi_aclk  in  1  sole clock; the controller's ddrphy_clkin.
- axi_aresetn  in  1  synchronous active-low reset; the controller's pll_lock.
- ddr_init_done  in  1  no AW is issued while low.
- in_valid  in  1  upstream word valid.
- in_data  in  MEM_DQ_WIDTH*8  upstream word.
- in_ready  out  1  high when the FIFO is not full.
- frame_sync  in  1  one-cycle pulse marking the start of a new frame.
- axi_awaddr  out  CTRL_ADDR_WIDTH  burst start address.
- axi_awuser_id  out  4  constant AXI_ID.
- axi_awlen  out  4  constant BURST_LEN-1.
- axi_awvalid  out  1  address valid.
- axi_awready  in  1  address accepted.
- axi_wdata  out  MEM_DQ_WIDTH*8  FIFO head word.
- axi_wstrb  out  MEM_DQ_WIDTH  all ones.
- axi_wready  in  1  controller consumes axi_wdata this cycle.
- axi_wusero_last  in  1  last beat marker from controller; used for checking only.
- cur_region  out  2  region index currently being written.
- frame_done  out  1  one-cycle pulse when a frame_sync takes effect.
- err_flag  out  1  sticky error; cleared only by reset.

Behaviour:
- Reset (axi_aresetn low at a clock edge) forces the following; reset mid-burst abandons the burst with no cleanup:
  - state = IDLE; FIFO emptied; in_ready = 0 during reset, 1 afterwards.
  - axi_awvalid = 0, axi_awaddr = BASE_ADDR, cur_region = 0.
  - frame_done = 0, err_flag = 0, sync_pending = 0.
- FIFO push: in_valid && in_ready. FIFO pop: axi_wready in state W.
  - Push and pop in the same cycle leave the count unchanged.
  - The count is FIFO_DEPTH+1-capable (full = count == FIFO_DEPTH).
  - axi_wdata is always the head word, combinational show-ahead; it is undefined when empty.
- FSM states: IDLE, AW, W.
  - IDLE -> AW when ddr_init_done && count >= BURST_LEN && !sync_pending. axi_awvalid rises on the next edge.
  - AW: hold axi_awvalid and axi_awaddr stable until axi_awready. On handshake, drop axi_awvalid, clear the beat counter and go to W.
  - W: each axi_wready cycle pops one word and increments the beat counter. After beat BURST_LEN-1:
    - advance axi_awaddr by BURST_LEN*8;
    - if the new offset equals REGION_SIZE, wrap to the region base, i.e. stay in the region and overwrite it;
    - return to IDLE.
  - In W, axi_wready while the FIFO is empty cannot occur by construction. If it does, set err_flag and do not pop.
  - axi_wusero_last high on a beat other than BURST_LEN-1 sets err_flag.
- frame_sync:
  - Arriving in any state, it sets sync_pending.
  - A frame_sync arriving while sync_pending is already set is merged.
  - sync_pending is applied in IDLE only, on the first IDLE cycle, taking priority over starting a burst.
- Applying sync_pending:
  - cur_region = (cur_region+1) mod REGION_NUM.
  - axi_awaddr = BASE_ADDR + new cur_region*REGION_SIZE.
  - Any residual FIFO words (count < BURST_LEN) are discarded. If the discarded count is nonzero, set err_flag.
  - frame_done pulses for 1 cycle; sync_pending clears.
  - A push in the same cycle as application is kept and belongs to the new frame.
  - frame_sync in the same cycle as application sets sync_pending again.
- Latency: from the BURST_LEN-th word pushed (state IDLE, init done) to axi_awvalid high is 2 cycles.
- Back-to-back bursts: W -> IDLE -> AW, giving a minimum of 1 idle cycle between bursts.

Test Plan:
1. Reset, ddr_init_done=1, push 16 words 0..15 at one per cycle. Required response:
   - axi_awvalid high 2 cycles after the 16th push, with axi_awaddr=0 and axi_awlen=4'hF;
   - after awready, 16 wready beats deliver data 0..15 in order;
   - axi_awaddr becomes 28'h80.
2. ddr_init_done=0 with 32 words pushed. Required response:
   - axi_awvalid stays 0 and in_ready=0 at 32 words;
   - raising ddr_init_done yields two bursts at addresses 0x0 and 0x80.
3. Hold axi_awready low for 10 cycles. Required response: axi_awvalid and axi_awaddr stay stable, and no FIFO pop occurs.
4. frame_sync mid-burst. Required response:
   - the burst completes;
   - then frame_done pulses, cur_region=1 and the next axi_awaddr is 28'h0200000;
   - three syncs total wrap cur_region back to 0 with address 0.
5. Push 5 words then frame_sync. Required response: 5 words are discarded, err_flag=1, cur_region advances, and no AW is issued.
6. Set REGION_SIZE=0x100 and write 3 bursts without sync. Required response: addresses are 0x0, 0x80, 0x0.
